// File: rtl/fire_conv_engine.sv
// Row of N_PE signed MAC lanes fed by one broadcast weight per beat.
// A small sequencer accumulates cfg_taps beats, then biases, rectifies and saturates.
module fire_conv_engine #(
  parameter int N_PE   = 9,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16,
  parameter int TAP_W  = 8
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TAP_W-1:0]         cfg_taps,
  input  logic                     cfg_reduce,
  input  logic                     cfg_relu,
  input  logic [ACC_W-1:0]         bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_PE*DATA_W-1:0]   in_data,
  input  logic [DATA_W-1:0]        in_weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_PE*OUT_W-1:0]    out_data,
  output logic [OUT_W-1:0]         out_sum,
  output logic                     busy
);

  localparam int SUM_W = ACC_W + $clog2(N_PE) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]              state_q,  state_d;
  logic [TAP_W-1:0]        taps_q,   taps_d;
  logic [TAP_W-1:0]        cnt_q,    cnt_d;
  logic                    reduce_q, reduce_d;
  logic                    relu_q,   relu_d;
  logic signed [ACC_W-1:0] bias_q,   bias_d;
  logic signed [ACC_W-1:0] acc_q [N_PE];
  logic signed [ACC_W-1:0] acc_d [N_PE];
  logic [N_PE*OUT_W-1:0]   out_data_q, out_data_d;
  logic [OUT_W-1:0]        out_sum_q,  out_sum_d;

  logic signed [ACC_W-1:0] acc_beat [N_PE];
  logic [OUT_W-1:0]        lane_res [N_PE];
  logic signed [SUM_W-1:0] sum_v;
  logic [TAP_W-1:0]        cnt_inc;

  // Everything is widened to SUM_W first, so the comparisons below never overflow.
  function automatic logic [OUT_W-1:0] relu_sat(input logic signed [SUM_W-1:0] v,
                                                input logic                    relu);
    logic signed [SUM_W-1:0] r;
    r = (relu && v[SUM_W-1]) ? '0 : v;
    if (r > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (r < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return r[OUT_W-1:0];
  endfunction

  for (genvar g = 0; g < N_PE; g++) begin : g_lane
    logic signed [2*DATA_W-1:0] prod;
    logic signed [SUM_W-1:0]    lane_v;
    assign prod        = $signed(in_data[g*DATA_W +: DATA_W]) * $signed(in_weight);
    assign acc_beat[g] = acc_q[g] + ACC_W'(prod);
    assign lane_v      = SUM_W'(acc_q[g]) + SUM_W'(bias_q);
    assign lane_res[g] = relu_sat(lane_v, relu_q);
  end

  always_comb begin
    sum_v = SUM_W'(bias_q);
    for (int i = 0; i < N_PE; i++) begin
      sum_v = sum_v + SUM_W'(acc_q[i]);
    end
  end

  assign cnt_inc = cnt_q + TAP_W'(1);

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    taps_d     = taps_q;
    cnt_d      = cnt_q;
    reduce_d   = reduce_q;
    relu_d     = relu_q;
    bias_d     = bias_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_sum_d  = out_sum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          taps_d   = cfg_taps;
          reduce_d = cfg_reduce;
          relu_d   = cfg_relu;
          bias_d   = bias;
          cnt_d    = '0;
          for (int i = 0; i < N_PE; i++) acc_d[i] = '0;
          state_d  = (cfg_taps == '0) ? S_FINISH : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_beat;
          cnt_d = cnt_inc;
          if (cnt_inc == taps_q) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        for (int i = 0; i < N_PE; i++) out_data_d[i*OUT_W +: OUT_W] = lane_res[i];
        out_sum_d = reduce_q ? relu_sat(sum_v, relu_q) : '0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      taps_q     <= '0;
      cnt_q      <= '0;
      reduce_q   <= 1'b0;
      relu_q     <= 1'b0;
      bias_q     <= '0;
      // NOTE: the accumulator array is plain flops, not a RAM, so it is cleared on reset so no residue survives an aborted pass.
      for (int i = 0; i < N_PE; i++) acc_q[i] <= '0;
      out_data_q <= '0;
      out_sum_q  <= '0;
    end else begin
      // NOTE: non-blocking updates let every flop sample the pre-edge values, independent of statement order.
      state_q    <= state_d;
      taps_q     <= taps_d;
      cnt_q      <= cnt_d;
      reduce_q   <= reduce_d;
      relu_q     <= relu_d;
      bias_q     <= bias_d;
      for (int i = 0; i < N_PE; i++) acc_q[i] <= acc_d[i];
      out_data_q <= out_data_d;
      out_sum_q  <= out_sum_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_fire_conv_engine.sv
// Directed bench for fire_conv_engine: reset, MAC pass, ReLU, saturation, stalls, zero taps.
module tb_fire_conv_engine;
  localparam int N_PE   = 9;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 16;
  localparam int TAP_W  = 8;

  logic                   Clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [TAP_W-1:0]       cfg_taps = '0;
  logic                   cfg_reduce = 1'b0;
  logic                   cfg_relu = 1'b0;
  logic [ACC_W-1:0]       bias = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [N_PE*DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0]      in_weight = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [N_PE*OUT_W-1:0]  out_data;
  logic [OUT_W-1:0]       out_sum;
  logic                   busy;

  int checks = 0;
  int failures = 0;

  fire_conv_engine #(
    .N_PE(N_PE), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .TAP_W(TAP_W)
  ) dut (
    .Clk(Clk), .reset(reset), .start(start), .cfg_taps(cfg_taps),
    .cfg_reduce(cfg_reduce), .cfg_relu(cfg_relu), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sum(out_sum), .busy(busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic signed [OUT_W-1:0] lane(input int i);
    return out_data[i*OUT_W +: OUT_W];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_all(input logic signed [DATA_W-1:0] v);
    for (int i = 0; i < N_PE; i++) in_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_start(input int taps, input logic reduce, input logic relu,
                          input logic signed [ACC_W-1:0] b);
    start = 1'b1; cfg_taps = TAP_W'(taps); cfg_reduce = reduce; cfg_relu = relu; bias = b;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (out_sum !== '0) begin failures++; $display("FAIL rst_out_sum got=%h exp=0", out_sum); end
    reset = 1'b1;
    tick();
    // interrupt a 9-tap pass after 4 beats
    do_start(9, 1'b1, 1'b0, 0);
    set_all(7); in_weight = 8'sd2; in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    reset = 1'b1;
    tick();
    do_start(1, 1'b1, 1'b0, 0);
    set_all(1); in_weight = 8'sd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL postrst_out_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < N_PE; i++) begin
      checks++; if (lane(i) !== 16'sd1) begin failures++; $display("FAIL postrst_lane%0d got=%0d exp=1", i, lane(i)); end
    end
    checks++; if ($signed(out_sum) !== 16'sd9) begin failures++; $display("FAIL postrst_sum got=%0d exp=9", $signed(out_sum)); end
    handshake();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL postrst_hs got=%b%b exp=00", out_valid, busy); end
  endtask

  task automatic test_3x3();
    do_start(9, 1'b1, 1'b0, 5);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL mac_start got=%b%b exp=11", busy, in_ready); end
    set_all(2); in_weight = 8'sd3; in_valid = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mac_in_ready_fall got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mac_finish_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mac_out_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < N_PE; i++) begin
      checks++; if (lane(i) !== 16'sd59) begin failures++; $display("FAIL mac_lane%0d got=%0d exp=59", i, lane(i)); end
    end
    checks++; if ($signed(out_sum) !== 16'sd491) begin failures++; $display("FAIL mac_sum got=%0d exp=491", $signed(out_sum)); end
    handshake();
  endtask

  task automatic run_relu(input logic relu, input logic signed [OUT_W-1:0] e0,
                          input logic signed [OUT_W-1:0] e1, input logic signed [OUT_W-1:0] e2);
    do_start(2, 1'b1, relu, -10);
    set_all(0);
    in_data[0 +: DATA_W] = -8'sd4; in_data[DATA_W +: DATA_W] = 8'sd4; in_weight = 8'sd3; in_valid = 1'b1;
    tick();
    in_data[0 +: DATA_W] = 8'sd5;  in_data[DATA_W +: DATA_W] = 8'sd5; in_weight = 8'sd1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (lane(0) !== e0) begin failures++; $display("FAIL relu%0b_lane0 got=%0d exp=%0d", relu, lane(0), e0); end
    checks++; if (lane(1) !== e1) begin failures++; $display("FAIL relu%0b_lane1 got=%0d exp=%0d", relu, lane(1), e1); end
    checks++; if (lane(2) !== e2) begin failures++; $display("FAIL relu%0b_lane2 got=%0d exp=%0d", relu, lane(2), e2); end
    checks++; if (out_sum !== '0) begin failures++; $display("FAIL relu%0b_sum got=%0d exp=0", relu, $signed(out_sum)); end
    handshake();
  endtask

  task automatic test_relu();
    run_relu(1'b0, -16'sd17, 16'sd7, -16'sd10);
    run_relu(1'b1, 16'sd0, 16'sd7, 16'sd0);
  endtask

  task automatic test_saturation();
    do_start(9, 1'b0, 1'b0, 0);
    set_all(127); in_weight = 8'sd127; in_valid = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < N_PE; i++) begin
      checks++; if (lane(i) !== 16'sd32767) begin failures++; $display("FAIL satpos_lane%0d got=%0d exp=32767", i, lane(i)); end
    end
    checks++; if (out_sum !== '0) begin failures++; $display("FAIL satpos_noreduce_sum got=%0d exp=0", $signed(out_sum)); end
    handshake();
    do_start(9, 1'b1, 1'b0, 0);
    in_weight = 8'h80; in_valid = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < N_PE; i++) begin
      checks++; if (lane(i) !== -16'sd32768) begin failures++; $display("FAIL satneg_lane%0d got=%0d exp=-32768", i, lane(i)); end
    end
    checks++; if ($signed(out_sum) !== -16'sd32768) begin failures++; $display("FAIL satneg_sum got=%0d exp=-32768", $signed(out_sum)); end
    handshake();
  endtask

  task automatic test_stalls();
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int k;
    k = 0;
    do_start(4, 1'b1, 1'b0, 0);
    in_weight = 8'sd1;
    for (int s = 0; s < 7; s++) begin
      in_valid = (pat[s] != 0);
      if (pat[s] != 0) begin k++; set_all(DATA_W'(k)); end
      else set_all(100);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_done_in_ready got=%b exp=0", in_ready); end
    tick();
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; cfg_taps = 8'd0; bias = 24'd77; in_valid = 1'b1; set_all(50);
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold%0d_valid got=%b exp=1", c, out_valid); end
      checks++; if (lane(0) !== 16'sd10 || lane(8) !== 16'sd10) begin failures++; $display("FAIL stall_hold%0d_data got=%0d,%0d exp=10,10", c, lane(0), lane(8)); end
    end
    start = 1'b0; in_valid = 1'b0;
    checks++; if ($signed(out_sum) !== 16'sd90) begin failures++; $display("FAIL stall_sum got=%0d exp=90", $signed(out_sum)); end
    handshake();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_taps0();
    do_start(0, 1'b1, 1'b0, -3);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL taps0_finish got=%b%b%b exp=010", out_valid, busy, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL taps0_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < N_PE; i++) begin
      checks++; if (lane(i) !== -16'sd3) begin failures++; $display("FAIL taps0_lane%0d got=%0d exp=-3", i, lane(i)); end
    end
    checks++; if ($signed(out_sum) !== -16'sd3) begin failures++; $display("FAIL taps0_sum got=%0d exp=-3", $signed(out_sum)); end
    handshake();
  endtask

  task automatic test_back_to_back();
    do_start(0, 1'b1, 1'b1, -3);
    tick();
    checks++; if (lane(0) !== 16'sd0 || out_sum !== '0) begin failures++; $display("FAIL b2b_relu got=%0d,%0d exp=0,0", lane(0), $signed(out_sum)); end
    // start held across the handshake edge is ignored there, accepted on the next edge
    out_ready = 1'b1; start = 1'b1; cfg_taps = 8'd0; cfg_relu = 1'b0; cfg_reduce = 1'b1; bias = 24'd4;
    tick();
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_hs got=%b%b exp=00", busy, out_valid); end
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
    tick();
    checks++; if (out_valid !== 1'b1 || lane(0) !== 16'sd4) begin failures++; $display("FAIL b2b_result got=%b/%0d exp=1/4", out_valid, lane(0)); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_3x3();
    test_relu();
    test_saturation();
    test_stalls();
    test_taps0();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
